// File: rtl/reg_share_arb.sv
// Round-robin write arbiter that owns a shared data register. One requester
// is granted at a time; its byte is captured during the grant cycle and the
// block then holds off for HOLD_CYC cycles before arbitrating again.
module reg_share_arb #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_din,
    output logic [NREQ-1:0]       o_gnt,
    output logic [WIDTH-1:0]      o_q,
    output logic [2:0]            o_owner,
    output logic                  o_q_valid,
    output logic                  o_busy
);

    localparam logic [3:0] NREQ4    = 4'(NREQ);
    localparam logic [2:0] LAST     = 3'(NREQ - 1);
    localparam logic [3:0] HOLD4    = 4'(HOLD_CYC);
    localparam bit         HAS_HOLD = (HOLD_CYC != 0);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StHold
    } state_e;

    state_e            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [WIDTH-1:0]  r_q;
    logic [2:0]        r_owner;
    logic              r_q_valid;
    logic [2:0]        r_ptr;
    logic [3:0]        r_cnt;

    state_e            w_state_nxt;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [WIDTH-1:0]  w_q_nxt;
    logic [2:0]        w_owner_nxt;
    logic              w_q_valid_nxt;
    logic [2:0]        w_ptr_nxt;
    logic [3:0]        w_cnt_nxt;

    // Requests padded to 8 bits so a 3-bit index never reaches past the vector.
    logic [7:0]        w_req8;
    logic              w_found;
    logic [2:0]        w_win;
    logic [3:0]        w_sum;
    logic [NREQ-1:0]   w_win_onehot;
    logic [WIDTH-1:0]  w_din_sel;
    logic              w_take;

    assign w_req8 = 8'(i_req);
    assign w_take = w_req8[r_owner];

    // Winner: first set request searching from ptr upward, wrapping mod NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + 4'(k);
            if (w_sum >= NREQ4) begin
                w_sum = w_sum - NREQ4;
            end
            if (!w_found && w_req8[w_sum[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[2:0];
            end
        end
    end

    // One-hot of the winner and data mux for the current owner.
    always_comb begin
        w_win_onehot = '0;
        w_din_sel    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_win_onehot[i] = (w_win == 3'(i));
            if (r_owner == 3'(i)) begin
                w_din_sel = i_din[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_q_nxt       = r_q;
        w_owner_nxt   = r_owner;
        w_q_valid_nxt = r_q_valid;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_nxt = StGrant;
                    w_gnt_nxt   = w_win_onehot;
                    w_owner_nxt = w_win;
                    w_ptr_nxt   = (w_win == LAST) ? 3'd0 : w_win + 3'd1;
                end
            end
            StGrant: begin
                w_gnt_nxt = '0;
                // Requester dropped req before its grant landed: abandon, no hold.
                if (w_take) begin
                    w_q_nxt       = w_din_sel;
                    w_q_valid_nxt = 1'b1;
                    if (HAS_HOLD) begin
                        w_state_nxt = StHold;
                        w_cnt_nxt   = HOLD4;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StHold: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers; synchronous reset discards any capture in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_gnt     <= '0;
            r_q       <= '0;
            r_owner   <= '0;
            r_q_valid <= 1'b0;
            r_ptr     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_q       <= w_q_nxt;
            r_owner   <= w_owner_nxt;
            r_q_valid <= w_q_valid_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_q       = r_q;
    assign o_owner   = r_owner;
    assign o_q_valid = r_q_valid;
    assign o_busy    = (r_state != StIdle);

endmodule

// File: tb/tb_reg_share_arb.sv
// Bench for reg_share_arb: vector table, directed corner sequences, a
// HOLD_CYC=0 instance, and random traffic against a behavioural model.
module tb_reg_share_arb;

    localparam int HOLD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (HOLD_CYC = 2).
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [2:0]  owner;
    logic        qv;
    logic        busy;

    // Zero-hold instance.
    logic        h_rst;
    logic [3:0]  h_req;
    logic [31:0] h_din;
    logic [3:0]  h_gnt;
    logic [7:0]  h_q;
    logic [2:0]  h_owner;
    logic        h_qv;
    logic        h_busy;

    reg_share_arb #(.NREQ(4), .WIDTH(8), .HOLD_CYC(HOLD)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_din    (din),
        .o_gnt    (gnt),
        .o_q      (q),
        .o_owner  (owner),
        .o_q_valid(qv),
        .o_busy   (busy)
    );

    reg_share_arb #(.NREQ(4), .WIDTH(8), .HOLD_CYC(0)) dut0 (
        .i_clk    (clk),
        .i_rst    (h_rst),
        .i_req    (h_req),
        .i_din    (h_din),
        .o_gnt    (h_gnt),
        .o_q      (h_q),
        .o_owner  (h_owner),
        .o_q_valid(h_qv),
        .o_busy   (h_busy)
    );

    logic [16:0] act_main;
    logic [16:0] act_h0;
    assign act_main = {gnt, q, owner, qv, busy};
    assign act_h0   = {h_gnt, h_q, h_owner, h_qv, h_busy};

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [16:0] pk(input logic [3:0] g, input logic [7:0] qq,
                                       input logic [2:0] o, input logic v, input logic b);
        return {g, qq, o, v, b};
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b q=%h owner=%0d q_valid=%b busy=%b, expected gnt=%b q=%h owner=%0d q_valid=%b busy=%b",
                     name, act[16:13], act[12:5], act[4:2], act[1], act[0],
                     exp[16:13], exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] din;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] d,
                       input logic [3:0] g, input logic [7:0] qq, input logic [2:0] o,
                       input logic v, input logic b);
        vec_t e;
        e.rst = r;
        e.req = rq;
        e.din = d;
        e.exp = pk(g, qq, o, v, b);
        tbl.push_back(e);
    endtask

    // Behavioural model: tracks whether a grant is outstanding and how many
    // hold cycles remain, plus the rotating priority start index.
    int          m_ptr;
    int          m_owner;
    int          m_left;
    logic        m_ing;
    logic [3:0]  m_gnt;
    logic [7:0]  m_q;
    logic        m_qv;

    task automatic model_step(input logic r, input logic [3:0] rq, input logic [31:0] d);
        int idx;
        if (r) begin
            m_ptr = 0; m_owner = 0; m_left = 0; m_ing = 1'b0;
            m_gnt = '0; m_q = '0; m_qv = 1'b0;
        end else if (m_ing) begin
            m_ing = 1'b0;
            m_gnt = '0;
            if (rq[m_owner]) begin
                m_q    = d[m_owner*8 +: 8];
                m_qv   = 1'b1;
                m_left = HOLD;
            end else begin
                m_left = 0;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (rq != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (rq[idx]) begin
                    m_owner = idx;
                    m_gnt   = 4'b0001 << idx;
                    m_ptr   = (idx + 1) % 4;
                    m_ing   = 1'b1;
                    break;
                end
            end
        end
    endtask

    function automatic logic [16:0] model_out();
        return pk(m_gnt, m_q, 3'(m_owner), m_qv, m_ing || (m_left > 0));
    endfunction

    localparam logic [31:0] DRR = 32'h13121110;
    localparam logic [31:0] DA5 = 32'h13A51110;

    initial begin
        rst   = 1'b1; req   = '0; din   = '0;
        h_rst = 1'b1; h_req = '0; h_din = '0;

        // Reset with all requests high, then single requester, then round-robin.
        for (int i = 0; i < 3; i++) add(1, 4'hF, DRR, 4'h0, 8'h00, 0, 0, 0);
        add(0, 4'h0, DA5, 4'h0, 8'h00, 0, 0, 0);
        add(0, 4'h4, DA5, 4'h4, 8'h00, 2, 0, 1);
        add(0, 4'h4, DA5, 4'h0, 8'hA5, 2, 1, 1);
        add(0, 4'h0, DA5, 4'h0, 8'hA5, 2, 1, 1);
        add(0, 4'h0, DA5, 4'h0, 8'hA5, 2, 1, 0);
        add(1, 4'h0, DRR, 4'h0, 8'h00, 0, 0, 0);
        add(0, 4'hF, DRR, 4'h1, 8'h00, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            add(0, 4'hF, DRR, 4'h0, 8'h10 + 8'(i), 3'(i), 1, 1);
            add(0, 4'hF, DRR, 4'h0, 8'h10 + 8'(i), 3'(i), 1, 1);
            add(0, 4'hF, DRR, 4'h0, 8'h10 + 8'(i), 3'(i), 1, 0);
            add(0, 4'hF, DRR, 4'h1 << ((i + 1) % 4), 8'h10 + 8'(i), 3'((i + 1) % 4), 1, 1);
        end
        add(0, 4'hF, DRR, 4'h0, 8'h10, 0, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; din = tbl[i].din;
            tick();
            check($sformatf("vec%0d", i), act_main, tbl[i].exp);
        end

        // Abandoned grant: req[1] only during the IDLE cycle.
        din = 32'h44332211;
        rst = 1'b1; req = 4'h0; tick(); check("abn_rst", act_main, pk(4'h0, 8'h00, 0, 0, 0));
        rst = 1'b0; req = 4'h2; tick(); check("abn_gnt", act_main, pk(4'h2, 8'h00, 1, 0, 1));
        req = 4'h0; tick(); check("abn_idle", act_main, pk(4'h0, 8'h00, 1, 0, 0));
        req = 4'h3; tick(); check("abn_wrap", act_main, pk(4'h1, 8'h00, 0, 0, 1));
        tick(); check("abn_cap", act_main, pk(4'h0, 8'h11, 0, 1, 1));

        // Reset asserted during GRANT discards the capture.
        din = 32'h00FF0000;
        rst = 1'b1; req = 4'h0; tick(); check("mid_rst0", act_main, pk(4'h0, 8'h00, 0, 0, 0));
        rst = 1'b0; req = 4'h4; tick(); check("mid_gnt", act_main, pk(4'h4, 8'h00, 2, 0, 1));
        rst = 1'b1; tick(); check("mid_rst", act_main, pk(4'h0, 8'h00, 0, 0, 0));
        rst = 1'b0; req = 4'hF; tick(); check("mid_ptr0", act_main, pk(4'h1, 8'h00, 0, 0, 1));

        // Zero-hold instance: grants alternate 0,2 every two cycles.
        h_din = 32'h00CC00AA;
        tick(); check("h0_rst", act_h0, pk(4'h0, 8'h00, 0, 0, 0));
        h_rst = 1'b0; h_req = 4'h5;
        for (int i = 0; i < 6; i++) begin
            logic [2:0] o;
            logic [7:0] eq;
            o = ((i / 2) % 2 == 0) ? 3'd0 : 3'd2;
            tick();
            if (i % 2 == 0) begin
                if (i == 0) eq = 8'h00;
                else eq = (o == 3'd0) ? 8'hCC : 8'hAA;
                check($sformatf("h0_gnt%0d", i), act_h0, pk(4'h1 << o, eq, o, i != 0, 1));
            end else begin
                eq = (o == 3'd0) ? 8'hAA : 8'hCC;
                check($sformatf("h0_idle%0d", i), act_h0, pk(4'h0, eq, o, 1, 0));
            end
        end

        // Random traffic against the behavioural model.
        rst = 1'b1; req = 4'h0;
        model_step(rst, req, din);
        tick();
        check("rnd_rst", act_main, model_out());
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            din = $urandom;
            model_step(rst, req, din);
            tick();
            check($sformatf("rnd%0d", i), act_main, model_out());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
